// File: rtl/uop_dispatch.sv
// Micro-op dispatch queue between issue and execute: a small FIFO with flush
// sequencing (RUN/FLUSH/HOLD), global advance enable and a saturating stall counter.
module uop_dispatch #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enabled,
  input  logic                     prev_valid,
  input  logic [WIDTH-1:0]         uop_in,
  output logic                     stalled,
  output logic                     valid,
  output logic [WIDTH-1:0]         uop_out,
  input  logic                     next_stalled,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [5:0]               stall_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [5:0]         stall_cnt_q, stall_cnt_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic               enq, deq;

  always_comb begin
    // Full asserts backpressure even if a dequeue happens this cycle (no bypass).
    stalled = (occ_q == OCC_W'(DEPTH)) || (state_q != RUN);
    valid   = (state_q == RUN) && (occ_q != '0);
    uop_out = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
    enq     = (state_q == RUN) && enabled && prev_valid && !stalled && !clear;
    deq     = enabled && valid && !next_stalled && !clear;

    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    stall_cnt_d = stall_cnt_q;
    mem_d       = mem_q;

    if (enq) begin
      mem_d[wr_ptr_q] = uop_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (enq && !deq) occ_d = occ_q + OCC_W'(1);
    else if (deq && !enq) occ_d = occ_q - OCC_W'(1);

    if (enabled && valid && next_stalled && (stall_cnt_q != 6'd63))
      stall_cnt_d = stall_cnt_q + 6'd1;

    case (state_q)
      FLUSH:   state_d = enabled ? RUN : HOLD;
      HOLD:    if (enabled) state_d = RUN;
      default: state_d = RUN;
    endcase

    // Flush overrides everything except reset, including the enable gate.
    if (clear) begin
      state_d     = FLUSH;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      stall_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign occupancy    = occ_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_uop_dispatch.sv
// Directed bench for uop_dispatch (DEPTH=4): fill, streaming, flush/hold,
// stall-counter saturation, wrap with alternating backpressure, enable gating and reset.
module tb_uop_dispatch;

  logic        clk = 1'b0;
  logic        reset, clear, enabled, prev_valid, next_stalled;
  logic [31:0] uop_in;
  logic        stalled, valid;
  logic [31:0] uop_out;
  logic [2:0]  occupancy;
  logic [5:0]  stall_cycles;

  int checks = 0;
  int errors = 0;

  uop_dispatch #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .enabled(enabled),
    .prev_valid(prev_valid), .uop_in(uop_in), .stalled(stalled),
    .valid(valid), .uop_out(uop_out), .next_stalled(next_stalled),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; enabled = 1'b1; prev_valid = 1'b0;
    next_stalled = 1'b0; uop_in = '0;
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] exp_q[$];
  int          sent;
  int          exp_occ;
  logic        m_enq, m_deq;

  initial begin
    // reset state
    do_reset();
    check("rst_occ", 32'(occupancy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_stalled", 32'(stalled), 0);
    check("rst_stallcnt", 32'(stall_cycles), 0);
    check("rst_uop_out", uop_out, 0);

    // fill with backpressure, 0x15 held upstream
    next_stalled = 1'b1; prev_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      uop_in = 32'h11 + 32'(i);
      tick();
      check("fill_occ", 32'(occupancy), 32'(i + 1));
    end
    check("fill_stalled", 32'(stalled), 1);
    uop_in = 32'h15;
    tick(); tick();
    check("fill_hold_occ", 32'(occupancy), 4);
    check("fill_hold_head", uop_out, 32'h11);
    next_stalled = 1'b0;
    check("full_deq_stalled", 32'(stalled), 1);
    tick();
    check("drain1_occ", 32'(occupancy), 3);
    check("drain1_head", uop_out, 32'h12);
    check("drain1_stalled", 32'(stalled), 0);
    tick();
    prev_valid = 1'b0;
    check("drain2_occ", 32'(occupancy), 3);
    check("drain2_head", uop_out, 32'h13);
    tick(); check("drain3_head", uop_out, 32'h14);
    tick(); check("drain4_head", uop_out, 32'h15);
    tick();
    check("drained_occ", 32'(occupancy), 0);
    check("drained_valid", 32'(valid), 0);
    check("drained_out", uop_out, 0);

    // streaming
    do_reset();
    prev_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      uop_in = 32'hA0 + 32'(i);
      tick();
      check("stream_valid", 32'(valid), 1);
      check("stream_out", uop_out, 32'hA0 + 32'(i));
      check("stream_occ", 32'(occupancy), 1);
    end
    prev_valid = 1'b0;
    tick();
    check("stream_end_valid", 32'(valid), 0);

    // flush with enabled=1 -> FLUSH -> RUN
    do_reset();
    next_stalled = 1'b1; prev_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      uop_in = 32'h31 + 32'(i);
      tick();
    end
    check("flush_pre_occ", 32'(occupancy), 3);
    clear = 1'b1; uop_in = 32'h34;
    tick();
    clear = 1'b0; uop_in = 32'h35; next_stalled = 1'b0;
    check("flush_occ", 32'(occupancy), 0);
    check("flush_valid", 32'(valid), 0);
    check("flush_stalled", 32'(stalled), 1);
    check("flush_out", uop_out, 0);
    tick();
    check("flush_run_stalled", 32'(stalled), 0);
    check("flush_run_occ", 32'(occupancy), 0);
    prev_valid = 1'b1;
    tick();
    prev_valid = 1'b0;
    check("flush_new_out", uop_out, 32'h35);
    tick();

    // clear with enabled=0 -> FLUSH -> HOLD -> RUN
    enabled = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("hold_flush_stalled", 32'(stalled), 1);
    tick();
    check("hold_stalled", 32'(stalled), 1);
    tick();
    check("hold_stays", 32'(stalled), 1);
    enabled = 1'b1;
    tick();
    check("hold_exit_stalled", 32'(stalled), 0);

    // stall counter saturation
    do_reset();
    next_stalled = 1'b1; prev_valid = 1'b1; uop_in = 32'h55;
    tick();
    prev_valid = 1'b0;
    for (int i = 0; i < 62; i++) tick();
    check("sat_62", 32'(stall_cycles), 62);
    tick();
    check("sat_63", 32'(stall_cycles), 63);
    for (int i = 0; i < 7; i++) tick();
    check("sat_hold", 32'(stall_cycles), 63);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("sat_clear", 32'(stall_cycles), 0);
    tick();

    // wrap with alternating backpressure (small queue model)
    do_reset();
    exp_q.delete();
    sent = 0; exp_occ = 0;
    for (int cyc = 0; cyc < 60 && (sent < 10 || exp_occ != 0); cyc++) begin
      prev_valid   = (sent < 10);
      uop_in       = 32'hC0 + 32'(sent);
      next_stalled = (cyc % 2 == 0);
      #1;
      check("wrap_stalled", 32'(stalled), 32'(exp_occ == 4));
      m_enq = prev_valid && (exp_occ != 4);
      m_deq = (exp_occ != 0) && !next_stalled;
      if (m_deq) begin
        check("wrap_order", uop_out, exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (m_enq) begin
        exp_q.push_back(uop_in);
        sent++;
      end
      tick();
      exp_occ = exp_q.size();
      check("wrap_occ", 32'(occupancy), 32'(exp_occ));
    end
    check("wrap_all_sent", 32'(sent), 10);
    check("wrap_drained", 32'(occupancy), 0);
    prev_valid = 1'b0;

    // enable gating and mid-operation reset
    do_reset();
    enabled = 1'b0; prev_valid = 1'b1; uop_in = 32'h77;
    tick(); tick();
    check("gate_no_enq", 32'(occupancy), 0);
    enabled = 1'b1; next_stalled = 1'b1;
    tick();
    uop_in = 32'h78;
    tick();
    check("gate_occ2", 32'(occupancy), 2);
    enabled = 1'b0; next_stalled = 1'b0;
    tick();
    check("gate_freeze_occ", 32'(occupancy), 2);
    check("gate_freeze_head", uop_out, 32'h77);
    enabled = 1'b1; prev_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_occ", 32'(occupancy), 0);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_out", uop_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uop_dispatch.md
UOP_DISPATCH -- requirements
Module: uop_dispatch

Interface
REQ-001 Parameter WIDTH, default 32, uop payload width in bits.
REQ-002 Parameter DEPTH, default 4, queue entries; the block SHALL support power of two values from 2 to 16.
REQ-003 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 clear  input  1  pipeline flush request; discards all queued uops.
REQ-006 enabled  input  1  global advance enable; while low, no enqueue, dequeue or counter update SHALL occur.
REQ-007 prev_valid  input  1  upstream issue stage presents a valid uop.
REQ-008 uop_in  input  WIDTH  uop payload from the issue stage.
REQ-009 stalled  output  1  backpressure to the issue stage; when high, upstream SHALL hold its uop.
REQ-010 valid  output  1  the uop at the queue head is valid for the execute stage.
REQ-011 uop_out  output  WIDTH  queue-head payload.
REQ-012 next_stalled  input  1  backpressure from the execute stage.
REQ-013 occupancy  output  clog2(DEPTH)+1  number of queued uops.
REQ-014 stall_cycles  output  6  saturating count of cycles in which valid=1 and next_stalled=1.

Function
REQ-015 The FSM SHALL have exactly three states: RUN, FLUSH and HOLD.
REQ-016 RUN: enqueue SHALL occur when enabled && prev_valid && !stalled; dequeue SHALL occur when enabled && valid && !next_stalled.
REQ-017 Enqueue and dequeue in the same cycle SHALL leave occupancy unchanged and preserve FIFO order.
REQ-018 stalled SHALL be combinational: 1 when occupancy==DEPTH, or when state is FLUSH or HOLD; otherwise 0.
REQ-019 A full queue SHALL assert stalled even when a dequeue occurs in the same cycle (no full-bypass).
REQ-020 valid SHALL be 1 only in RUN with occupancy!=0; uop_out SHALL equal the oldest entry, with no combinational path from uop_in.
REQ-021 Latency: a uop enqueued in cycle N SHALL appear on uop_out with valid=1 in cycle N+1 at the earliest.
REQ-022 clear=1 in any state SHALL, at the next edge, empty the queue (occupancy=0, read and write pointers to 0) and move to FLUSH; an enqueue or dequeue in that cycle SHALL be discarded.
REQ-023 clear SHALL take priority over enabled.
REQ-024 FLUSH SHALL last exactly one cycle, with stalled=1 and valid=0, then go to HOLD if enabled=0 or to RUN if enabled=1.
REQ-025 HOLD SHALL go to RUN on the first cycle with enabled=1.
REQ-026 In RUN, enabled=0 SHALL freeze the queue, pointers and stall_cycles; no state change occurs.
REQ-027 Pointers SHALL wrap modulo DEPTH, and occupancy SHALL never exceed DEPTH or underflow below 0.
REQ-028 stall_cycles SHALL increment when enabled && valid && next_stalled, saturate at 63, and reset to 0 on clear.

Reset
REQ-029 reset SHALL have priority over clear and all other inputs.
REQ-030 After reset: state=RUN, occupancy=0, pointers=0, valid=0, stalled=0, stall_cycles=0, uop_out=0.
REQ-031 reset asserted mid-operation SHALL discard all queued uops on the next edge.
REQ-032 Queue storage need not be reset, but uop_out SHALL read 0 whenever occupancy=0.

Verification
REQ-033 Fill: DEPTH=4, next_stalled=1, prev_valid=1 with uops 0x11..0x14 -> occupancy reaches 4, stalled=1 from the following cycle, and 0x15 is held upstream, not lost.
REQ-034 Streaming: next_stalled=0, back-to-back uops 0xA0..0xA7 -> uop_out delivers 0xA0..0xA7 in order, one cycle after each enqueue, and occupancy never exceeds 1.
REQ-035 Flush: 3 uops queued, clear pulsed -> next cycle occupancy=0, valid=0, stalled=1 (FLUSH), then RUN, and no old uop ever appears on uop_out.
REQ-036 Saturation: valid=1 with next_stalled=1 for 70 cycles -> stall_cycles=63 and holds; clear -> 0.
REQ-037 Wrap and simultaneous: 10 uops with alternating next_stalled and occupancy at DEPTH during simultaneous enqueue and dequeue -> stalled holds, order is preserved across pointer wrap, and none are dropped or duplicated.
REQ-038 Enable gating and reset: enabled=0 with prev_valid=1 -> no enqueue; reset asserted while 2 uops are queued -> occupancy=0, valid=0 the next cycle.
